sch_sweep_ctrl: RTL and testbench



---
 rtl/sch_sweep_ctrl.sv | 110 +++++++++++
 tb/tb_sch_sweep_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sch_sweep_ctrl.sv
// Exhaustive operand sweeper for cross-checking two Sch datapath implementations.
// Drives every operand vector, waits a settle time, compares both result words and logs failures.
module sch_sweep_ctrl #(
  parameter int unsigned N      = 4,
  parameter int unsigned SETTLE = 1,
  localparam int unsigned VW    = 5 * N + 1,
  localparam int unsigned RW    = 4 * N + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  output logic          busy,
  output logic          done,
  output logic          cin,
  output logic [N-1:0]  a1,
  output logic [N-1:0]  a0,
  output logic [N-1:0]  m2,
  output logic [N-1:0]  m1,
  output logic [N-1:0]  m0,
  input  logic [RW-1:0] res1,
  input  logic [RW-1:0] res2,
  output logic [15:0]   mismatch_cnt,
  output logic          first_bad_valid,
  output logic [VW-1:0] first_bad_vec
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam int unsigned CW = (SETTLE < 2) ? 1 : $clog2(SETTLE);
  localparam logic [CW-1:0] RELOAD = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
  // With no settle time each vector is compared in the cycle it appears.
  localparam state_t AFTER_VEC = (SETTLE > 0) ? S_SETTLE : S_CHECK;

  state_t        state;
  logic [VW-1:0] vec;
  logic [CW-1:0] settle_cnt;

  assign {cin, a1, a0, m2, m1, m0} = vec;

  // NOTE: every register here uses non-blocking assignment so all branches see this edge's values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      vec             <= '0;
      settle_cnt      <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      mismatch_cnt    <= '0;
      first_bad_valid <= 1'b0;
      first_bad_vec   <= '0;
    end else if (stop) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            vec             <= '0;
            mismatch_cnt    <= '0;
            first_bad_valid <= 1'b0;
            done            <= 1'b0;
            busy            <= 1'b1;
            settle_cnt      <= RELOAD;
            state           <= AFTER_VEC;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        S_CHECK: begin
          if (res1 != res2) begin
            if (mismatch_cnt != 16'hFFFF) begin
              mismatch_cnt <= mismatch_cnt + 16'd1;
            end
            if (!first_bad_valid) begin
              first_bad_vec   <= vec;
              first_bad_valid <= 1'b1;
            end
          end
          if (&vec) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            vec        <= vec + 1'b1;
            settle_cnt <= RELOAD;
            state      <= AFTER_VEC;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sch_sweep_ctrl.sv
// Bench for sch_sweep_ctrl: N=2 instances with SETTLE=1 and SETTLE=0, a behavioural Sch stand-in,
// and a queue of expected sweep outcomes popped when done rises.
module tb_sch_sweep_ctrl;

  localparam int N  = 2;
  localparam int VW = 5 * N + 1;
  localparam int RW = 4 * N + 1;

  typedef struct {
    int          cycles;
    logic [15:0] cnt;
    logic        fbv;
    logic [10:0] fbvec;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // SETTLE=1 instance
  logic          start_a = 1'b0, stop_a = 1'b0;
  logic          busy_a, done_a, cin_a, fbv_a;
  logic [N-1:0]  a1_a, a0_a, m2_a, m1_a, m0_a;
  logic [RW-1:0] res1_a, res2_a;
  logic [15:0]   cnt_a;
  logic [VW-1:0] fbvec_a, vec_a;

  // SETTLE=0 instance
  logic          start_z = 1'b0, stop_z = 1'b0;
  logic          busy_z, done_z, cin_z, fbv_z;
  logic [N-1:0]  a1_z, a0_z, m2_z, m1_z, m0_z;
  logic [RW-1:0] res1_z, res2_z;
  logic [15:0]   cnt_z;
  logic [VW-1:0] fbvec_z, vec_z;

  int   mode = 0;
  logic sel_z = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  sch_sweep_ctrl #(.N(N), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .busy(busy_a), .done(done_a),
    .cin(cin_a), .a1(a1_a), .a0(a0_a), .m2(m2_a), .m1(m1_a), .m0(m0_a),
    .res1(res1_a), .res2(res2_a), .mismatch_cnt(cnt_a),
    .first_bad_valid(fbv_a), .first_bad_vec(fbvec_a)
  );

  sch_sweep_ctrl #(.N(N), .SETTLE(0)) dut_z (
    .clk(clk), .rst(rst), .start(start_z), .stop(stop_z), .busy(busy_z), .done(done_z),
    .cin(cin_z), .a1(a1_z), .a0(a0_z), .m2(m2_z), .m1(m1_z), .m0(m0_z),
    .res1(res1_z), .res2(res2_z), .mismatch_cnt(cnt_z),
    .first_bad_valid(fbv_z), .first_bad_vec(fbvec_z)
  );

  assign vec_a = {cin_a, a1_a, a0_a, m2_a, m1_a, m0_a};
  assign vec_z = {cin_z, a1_z, a0_z, m2_z, m1_z, m0_z};

  function automatic logic [RW-1:0] sch_model(input logic [10:0] v);
    logic [3:0] sum;
    sum = v[3:0] + v[7:4];
    return {v[10] ^ v[0], v[9:6] ^ v[5:2], sum};
  endfunction

  function automatic logic fault(input int m, input logic [10:0] v);
    case (m)
      1:       return v == 11'h155;
      2:       return v[10];
      3:       return v < 11'd5;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    res1_a = sch_model(vec_a);
    res2_a = res1_a ^ {{(RW-1){1'b0}}, fault(mode, vec_a)};
    res1_z = sch_model(vec_z);
    res2_z = res1_z ^ {{(RW-1){1'b0}}, fault(mode, vec_z)};
  end

  logic          busy_o, done_o, fbv_o;
  logic [15:0]   cnt_o;
  logic [VW-1:0] vec_o, fbvec_o;
  assign busy_o  = sel_z ? busy_z  : busy_a;
  assign done_o  = sel_z ? done_z  : done_a;
  assign fbv_o   = sel_z ? fbv_z   : fbv_a;
  assign cnt_o   = sel_z ? cnt_z   : cnt_a;
  assign vec_o   = sel_z ? vec_z   : vec_a;
  assign fbvec_o = sel_z ? fbvec_z : fbvec_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      $error("check %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Full sweep from start to done, with the expected outcome derived from the fault model.
  task automatic run_sweep(input bit z, input int m, input int settle);
    exp_t e;
    int   cyc;
    bit   ok;
    e.cycles = 2048 * (settle + 1);
    e.cnt    = '0;
    e.fbv    = 1'b0;
    e.fbvec  = '0;
    for (int v = 0; v < 2048; v++) begin
      if (fault(m, 11'(v))) begin
        if (!e.fbv) e.fbvec = 11'(v);
        e.fbv = 1'b1;
        e.cnt++;
      end
    end
    exp_q.push_back(e);
    sel_z = z;
    mode  = m;
    @(negedge clk);
    if (z) start_z = 1'b1;
    else   start_a = 1'b1;
    @(posedge clk);
    cyc = 0;
    ok  = 1'b0;
    while (cyc <= 3 * e.cycles) begin
      @(negedge clk);
      start_a = 1'b0;
      start_z = 1'b0;
      if (cyc == 0) begin
        check("start_busy", 32'(busy_o), 32'd1);
        check("start_vec", 32'(vec_o), 32'd0);
        check("start_cnt", 32'(cnt_o), 32'd0);
        check("start_fbv", 32'(fbv_o), 32'd0);
      end
      if (z && cyc < 2048) check("z_vec_step", 32'(vec_o), 32'(cyc));
      if (done_o) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      cyc++;
    end
    if (!ok) check("done_timeout", 32'd0, 32'd1);
    e = exp_q.pop_front();
    check("sweep_cycles", 32'(cyc), 32'(e.cycles));
    check("sweep_cnt", 32'(cnt_o), 32'(e.cnt));
    check("sweep_fbv", 32'(fbv_o), 32'(e.fbv));
    if (e.fbv) check("sweep_fbvec", 32'(fbvec_o), 32'(e.fbvec));
    check("sweep_busy_low", 32'(busy_o), 32'd0);
    check("sweep_final_vec", 32'(vec_o), 32'h7FF);
  endtask

  // Start a sweep on the SETTLE=1 instance and stop sampling once vec reaches target.
  task automatic run_to_vec(input int m, input logic [10:0] target);
    bit ok;
    sel_z = 1'b0;
    mode  = m;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (vec_a == target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("reach_vec_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_vec", 32'(vec_a), 32'd0);
    check("rst_cnt", 32'(cnt_a), 32'd0);
    check("rst_fbv", 32'(fbv_a), 32'd0);
    check("rst_done_z", 32'(done_z), 32'd0);

    run_sweep(1'b0, 0, 1);
    run_sweep(1'b0, 1, 1);
    run_sweep(1'b0, 2, 1);
    run_sweep(1'b1, 0, 0);

    // Abort at 0x0A0 after five early mismatches.
    run_to_vec(3, 11'h0A0);
    stop_a = 1'b1;
    @(negedge clk);
    stop_a = 1'b0;
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_done", 32'(done_a), 32'd0);
    check("abort_vec", 32'(vec_a), 32'h0A0);
    check("abort_cnt", 32'(cnt_a), 32'd5);
    check("abort_fbvec", 32'(fbvec_a), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_idle_vec", 32'(vec_a), 32'h0A0);
    start_a = 1'b1;
    stop_a  = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    stop_a  = 1'b0;
    check("startstop_busy", 32'(busy_a), 32'd0);
    check("startstop_vec", 32'(vec_a), 32'h0A0);
    check("startstop_cnt", 32'(cnt_a), 32'd5);
    run_sweep(1'b0, 3, 1);

    // Reset mid-sweep with a start pulse overlapping the reset cycle.
    run_to_vec(3, 11'h300);
    check("pre_rst_cnt", 32'(cnt_a), 32'd5);
    rst     = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy_a), 32'd0);
    check("midrst_vec", 32'(vec_a), 32'd0);
    check("midrst_cnt", 32'(cnt_a), 32'd0);
    check("midrst_fbv", 32'(fbv_a), 32'd0);
    check("midrst_fbvec", 32'(fbvec_a), 32'd0);
    rst     = 1'b0;
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    check("postrst_idle", 32'(busy_a), 32'd0);
    check("postrst_done", 32'(done_a), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
